// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial sequence detector.
// Matches a runtime-loaded pattern of 1..MAX_LEN bits against the qualified
// serial input and supports overlapping or non-overlapping detection.
// The match output is a registered one-cycle pulse.
// Optional feature macro SEQDET_COUNT_EN adds a saturating match counter.
// When the macro is undefined, match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PAT = 8'b0001_1010,
    parameter int                 DEFAULT_LEN = 7,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [MAX_LEN-1:0] hist
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEFAULT_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               overlap_q, overlap_d;
    logic               match_q, match_d;

    logic [MAX_LEN-1:0] new_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic               hit;

    // Candidate history, active-length mask, fill arithmetic and hit detection
    always_comb begin
        new_hist = {hist_q[MAX_LEN-2:0], x};
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (32'(i) < 32'(len_q));
        end
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
        fill_sat = (fill_q == MAX_LEN_L) ? fill_q : fill_inc[LEN_W-1:0];
        // A hit requires a nonzero length and at least len fresh samples,
        // so that zero-initialised history never produces a match.
        hit = valid && !cfg_we && (len_q != '0)
              && (fill_inc >= {1'b0, len_q})
              && (((new_hist ^ pat_q) & len_mask) == '0);
    end

    // Next-state logic: configuration load takes precedence over sampling
    always_comb begin
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        match_d   = 1'b0;
        if (cfg_we) begin
            pat_d     = cfg_pat;
            len_d     = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (valid) begin
            hist_d  = new_hist;
            match_d = hit;
            // Non-overlapping mode consumes the matched bits by restarting the fill count.
            fill_d  = (hit && !overlap_q) ? '0 : fill_sat;
        end
    end

    // State registers with synchronous reset to the default pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            pat_q     <= DEFAULT_PAT;
            len_q     <= DEF_LEN_L;
            fill_q    <= '0;
            overlap_q <= 1'b1;
            match_q   <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
        end
    end

    assign match = match_q;
    assign hist  = hist_q;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear coinciding with a hit counts that hit
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, untouched by configuration loads
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Testbench for seq_detector_prog: a queue-based reference model driven by
// directed scenarios and by randomized traffic.
`timescale 1ns/1ps
module tb_seq_detector_prog;
    localparam int         MAX_LEN = 8;
    localparam int         CNT_W   = 2;
    localparam int         LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [7:0] DEF_PAT = 8'b0001_1010;
    localparam int         DEF_LEN = 7;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, x, valid, cfg_we, cfg_overlap, cnt_clr;
    logic [7:0]       cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [7:0]       hist;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .DEFAULT_PAT(DEF_PAT), .DEFAULT_LEN(DEF_LEN)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .valid(valid), .cfg_we(cfg_we),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .hist(hist)
    );

    // Reference model state: the bits received since the last clear,
    // the number of bits still usable for a match, and the active config.
    int         m_bits[$];
    int         m_since = 0;
    logic [7:0] m_pat   = DEF_PAT;
    int         m_len   = DEF_LEN;
    bit         m_ovl   = 1'b1;
    bit         e_match = 1'b0;
    int         e_cnt   = 0;
    bit         chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_hist();
        logic [7:0] h;
        h = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < m_bits.size()) h[i] = m_bits[m_bits.size() - 1 - i][0];
        end
        return h;
    endfunction

    function automatic int cnt_lit(input int n);
`ifdef SEQDET_COUNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0;
`endif
    endfunction

    // Reference model: evaluated from the inputs present at each rising edge
    always @(posedge clk) begin
        bit hitm;
        bit eq;
        hitm = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_since = 0;
            m_pat   = DEF_PAT;
            m_len   = DEF_LEN;
            m_ovl   = 1'b1;
            e_cnt   = 0;
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pat;
                m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
                m_ovl = cfg_overlap;
                m_bits.delete();
                m_since = 0;
            end else if (valid) begin
                m_bits.push_back(int'(x));
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                m_since++;
                if (m_len != 0 && m_since >= m_len) begin
                    eq = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) eq = 1'b0;
                    end
                    hitm = eq;
                end
                if (hitm && !m_ovl) m_since = 0;
            end
`ifdef SEQDET_COUNT_EN
            if (cnt_clr) e_cnt = hitm ? 1 : 0;
            else if (hitm && e_cnt < CNT_MAX) e_cnt++;
`else
            e_cnt = 0;
`endif
        end
        e_match = hitm;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_match", 32'(match), 32'(e_match));
            check("model_cnt", 32'(match_cnt), 32'(e_cnt));
            check("model_hist", 32'(hist), 32'(model_hist()));
        end
    end

    task automatic send(input logic b);
        x = b;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] p, input int l, input logic o);
        cfg_we = 1'b1;
        cfg_pat = p;
        cfg_len = LEN_W'(l);
        cfg_overlap = o;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] seq7;
        logic [7:0] pa5;
        rst = 1'b1; x = 1'b0; valid = 1'b0; cfg_we = 1'b0; cfg_overlap = 1'b0;
        cnt_clr = 1'b0; cfg_pat = '0; cfg_len = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_match", 32'(match), 32'd0);
        check("rst_hist", 32'(hist), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);

        // Default pattern 0011010, first bit sent first
        seq7 = 8'b0001_1010;
        for (int i = 6; i >= 1; i--) send(seq7[i]);
        check("def_no_early", 32'(match), 32'd0);
        send(seq7[0]);
        check("def_match", 32'(match), 32'd1);
        check("def_cnt", 32'(match_cnt), 32'(cnt_lit(1)));
        gap(1);
        check("def_pulse_end", 32'(match), 32'd0);

        clr_cnt();
        check("clr_alone", 32'(match_cnt), 32'd0);

        // Overlapping 1010
        do_cfg(8'b0000_1010, 4, 1'b1);
        send(1); send(0); send(1); send(0);
        check("ovl_hit4", 32'(match), 32'd1);
        send(1);
        check("ovl_miss5", 32'(match), 32'd0);
        send(0);
        check("ovl_hit6", 32'(match), 32'd1);
        check("ovl_cnt", 32'(match_cnt), 32'(cnt_lit(2)));

        // Non-overlapping 1010
        do_cfg(8'b0000_1010, 4, 1'b0);
        send(1); send(0); send(1); send(0);
        check("novl_hit4", 32'(match), 32'd1);
        send(1); send(0);
        check("novl_no6", 32'(match), 32'd0);
        send(1); send(0);
        check("novl_hit8", 32'(match), 32'd1);

        // Valid gap in the middle of the default pattern
        do_rst();
        send(0); send(0); send(1);
        gap(3);
        check("gap_hist", 32'(hist), 32'h01);
        check("gap_match", 32'(match), 32'd0);
        send(1); send(0); send(1); send(0);
        check("gap_hit", 32'(match), 32'd1);
        check("gap_hist_full", 32'(hist), 32'h1A);

        // All-zero pattern: fill gating
        do_rst();
        do_cfg(8'h00, 4, 1'b1);
        send(0); send(0); send(0);
        check("zero_gate", 32'(match), 32'd0);
        send(0);
        check("zero_hit", 32'(match), 32'd1);

        // Reset mid-pattern
        do_rst();
        for (int i = 6; i >= 1; i--) send(seq7[i]);
        do_rst();
        send(0);
        check("rst_mid", 32'(match), 32'd0);

        // Configuration load drops a simultaneous sample
        send(1);
        cfg_we = 1'b1; valid = 1'b1; x = 1'b1;
        cfg_pat = DEF_PAT; cfg_len = LEN_W'(DEF_LEN); cfg_overlap = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; valid = 1'b0;
        check("cfg_drop_hist", 32'(hist), 32'd0);
        check("cfg_drop_match", 32'(match), 32'd0);

        // Length clamp 9 -> 8
        pa5 = 8'hA5;
        do_cfg(pa5, 9, 1'b1);
        for (int i = 7; i >= 1; i--) send(pa5[i]);
        check("clamp_no7", 32'(match), 32'd0);
        send(pa5[0]);
        check("clamp_hit", 32'(match), 32'd1);

        // Length zero never matches
        do_cfg(8'h00, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'($urandom_range(0, 1)));
            check("len0", 32'(match), 32'd0);
        end

        // Counter saturation and clear-with-hit
        clr_cnt();
        do_cfg(8'h01, 1, 1'b1);
        repeat (5) send(1);
        check("cnt_sat", 32'(match_cnt), 32'(cnt_lit(5)));
        cnt_clr = 1'b1;
        send(1);
        cnt_clr = 1'b0;
        check("cnt_clr_hit", 32'(match_cnt), 32'(cnt_lit(1)));
        check("cnt_clr_hit_m", 32'(match), 32'd1);

        // Randomized traffic with occasional reconfiguration and resets
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            cfg_we  = ($urandom_range(0, 49) == 0);
            cfg_pat = 8'($urandom);
            cfg_len = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, 15))
                                                  : LEN_W'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom_range(0, 1));
            valid   = ($urandom_range(0, 3) != 0);
            x       = 1'($urandom_range(0, 1));
            cnt_clr = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; cfg_we = 1'b0; valid = 1'b0; cnt_clr = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Programmable serial sequence detector for the lab bit-stream datapath. It matches a runtime-loaded pattern of 1..MAX_LEN bits against a qualified serial input, with selectable overlapping or non-overlapping detection. A registered one-cycle match pulse and an optional saturating match counter feed downstream control logic.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, match counter width
- DEFAULT_PAT, 8'b0001_1010, pattern loaded at reset (LSB = most recent bit)
- DEFAULT_LEN, 7, pattern length loaded at reset
- LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- x  in  1  serial data bit
- valid  in  1  x is sampled this cycle only when high
- cfg_we  in  1  load cfg_pat/cfg_len/cfg_overlap
- cfg_pat  in  MAX_LEN  pattern; bit 0 = last bit received, bit len-1 = first
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping detection
- cnt_clr  in  1  clear match counter
- match  out  1  registered match pulse
- match_cnt  out  CNT_W  saturating match count
- hist  out  MAX_LEN  shift history, bit 0 newest

## Operation
- Registers: hist[MAX_LEN], fill (0..MAX_LEN, saturating), pat, len, overlap, match, match_cnt.
- Reset: hist=0, fill=0, pat=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1, match=0, match_cnt=0.
- Priority per edge: rst > cfg_we > valid.
- cfg_we: latch pat; len = cfg_len clamped to MAX_LEN if larger; overlap = cfg_overlap. Clear hist and fill. A valid sample on the same cycle is discarded. match=0.
- valid=1, no cfg_we: new = {hist[MAX_LEN-2:0], x}; hist <= new. hit = (len≠0) && (fill+1 ≥ len) && (new[len-1:0] == pat[len-1:0]).
- hit=1: match<=1.
  - overlap=1: fill <= min(fill+1, MAX_LEN).
  - overlap=0: fill <= 0, so the next hit needs len fresh bits; hist is still updated.
- hit=0: match<=0; fill <= min(fill+1, MAX_LEN).
- valid=0: hist and fill hold; match<=0.
- Fill gating: a match is never reported from zero-initialised history bits. After reset or cfg_we, at least len valid samples are required.
- len=0: match never asserts.
- Counter: on a hit, match_cnt <= match_cnt+1, saturating at 2^CNT_W−1.
  - cnt_clr alone sets 0.
  - cnt_clr together with a hit sets 1.
  - cfg_we does not clear the counter.

## Timing
- Latency: x sampled at edge N gives match high from edge N to N+1. The pulse is exactly one cycle per hit.
- match_cnt updates on the same edge as match.
- Back-to-back hits (overlap mode, valid every cycle) give match high on consecutive cycles.
- hist reflects a sample one cycle after its edge.
- rst mid-pattern: partial progress is lost; the next match needs a full len fresh bits.
- No combinational path from any input to any output.

## Configuration
- SEQDET_COUNT_EN
  - Defined: match_cnt and cnt_clr behave as in Operation.
  - Undefined: no counter register; match_cnt is tied to 0 and cnt_clr is ignored. match/hist behaviour is identical.

## Test plan
- Defaults, valid every cycle, stream 0,0,1,1,0,1,0 → match=1 only in the cycle after the 7th bit; match_cnt=1.
- cfg pat=4'b1010 (first bit 1), len=4, overlap=1; stream 1,0,1,0,1,0 → match after bits 4 and 6; count=2. Same with overlap=0 and stream 1,0,1,0,1,0,1,0 → match after bits 4 and 8 only.
- Defaults, valid deasserted for 3 cycles between bits 3 and 4 of 0011010 → exactly one match, after the 7th valid bit; hist holds during the gap.
- Gating and reset:
  - pat=0, len=4 after reset; 3 zero bits → no match; 4th zero → match.
  - Defaults: 6 bits of the pattern, rst, then final 0 → no match.
- Config edge cases:
  - cfg_we with valid=1 → sample dropped, hist=0.
  - cfg_len=9 with MAX_LEN=8 → len reads as 8 and an 8-bit pattern matches.
  - cfg_len=0 → no match for 20 random bits.
- Counter (SEQDET_COUNT_EN, CNT_W=2):
  - 5 matches → match_cnt stays 3.
  - cnt_clr on a hit cycle → 1.
  - Without macro → match_cnt=0 throughout.
